lcd_line_writer: RTL and testbench
==================================

// Module: lcd_line_writer
// PURPOSE
//  Downstream consumer of the line-formatter stage: takes one packed 11-char ASCII line (77 bits,
//  7 bits/char, leftmost char in [76:70]) and writes it to a row of an HD44780 16x2 LCD in 8-bit mode.
//  Issues a DDRAM set-address command, then 11 data writes, each with E-pulse and settle timing.
//  Sits between the formatter and the LCD pins; a sequencer pulses start once per line update.
// PARAMETERS
//  SETUP_CYC     2       cycles RS/DB stable before E rises (>=1)
//  E_HIGH_CYC    12      cycles E held high (>=1)
//  WAIT_CYC      2000    cycles after E falls before next write (execution time)
//  CLR_WAIT_CYC  82000   post-E wait for clear-display command (init only)
//  PWR_WAIT_CYC  750000  power-on wait before first init command (init only)
// PORTS
//  clk       in   1   system clock
//  rst       in   1   asynchronous, active-high reset
//  start     in   1   one-cycle request; sampled only while busy=0
//  row       in   1   target row: 0 -> DDRAM 0x00, 1 -> DDRAM 0x40
//  dat       in   77  packed ASCII line, char0=[76:70] .. char10=[6:0]
//  busy      out  1   high from the cycle after accepted start until done
//  done      out  1   one-cycle pulse when the line is fully written
//  lcd_rs    out  1   0=command, 1=data
//  lcd_rw    out  1   tied 0 (write only)
//  lcd_e     out  1   enable strobe
//  lcd_db    out  8   data bus
// BEHAVIOUR
//  Reset (async, any state): busy=0, done=0, lcd_rs=0, lcd_rw=0, lcd_e=0, lcd_db=8'h00, state IDLE,
//  all counters 0; an in-progress line is abandoned and not resumed.
//  Write cycle (one "write" = SETUP -> E_HIGH -> WAIT): RS/DB driven on SETUP entry and held unchanged
//  through WAIT; lcd_e high exactly E_HIGH_CYC cycles; write length T = SETUP_CYC+E_HIGH_CYC+WAIT_CYC.
//  States: IDLE, SETUP, E_HIGH, WAIT, NEXT, FIN (+ INIT_* under LCD_INIT_EN).
//  IDLE & start & !busy: latch dat and row; next cycle busy=1, SETUP with rs=0, db={1'b1,row,6'b0}.
//  NEXT: idx 0..10 selects char; rs=1, db={1'b0,char}; char value 7'h00 is sent as 8'h20 (space).
//  After write idx=10 completes: FIN for one cycle with done=1, busy=0; then IDLE. Total 12 writes;
//  done occurs 12*T + 12 cycles after the start-sampling edge (one NEXT/FIN cycle per write).
//  start while busy=1: ignored, no queueing. dat/row changes while busy: no effect (latched copy used).
//  start in the FIN cycle: ignored; accepted from the following IDLE cycle.
//  Char index counter 4 bits, saturates at 10; delay counter wide enough for max(PWR_WAIT_CYC) (20 bits).
// CONFIGURATION
//  LCD_INIT_EN defined: after reset, busy=1 and the block runs power-on init before accepting start:
//   wait PWR_WAIT_CYC; 0x38 x3; 0x0C (display on, cursor off); 0x01 (clear, waits CLR_WAIT_CYC
//   instead of WAIT_CYC); 0x06 (entry increment); all rs=0; then busy=0, IDLE. No done pulse for init.
//  LCD_INIT_EN undefined: block enters IDLE with busy=0 immediately after reset; display init is the
//   responsibility of an external sequencer.
// STRUCTURE
//  Shared include lcd_defs.vh: LCD command constants (FUNC_SET_8B2L=8'h38, DISP_ON=8'h0C, CLR=8'h01,
//  ENTRY_INC=8'h06, DDRAM_ROW0=8'h80, DDRAM_ROW1=8'hC0), state encodings, CHARS_PER_LINE=11, CHAR_W=7.
//  Sub-module lcd_write_timer: loadable down-counter with phase outputs (setup/e_high/wait done)
//  driving one write; the FSM in lcd_line_writer sequences addresses, chars and init commands.
// TESTING (sim params SETUP_CYC=2, E_HIGH_CYC=3, WAIT_CYC=5, CLR_WAIT_CYC=9, PWR_WAIT_CYC=20; T=10)
//  1 row=0, dat="TOT:3 12.34$"-style {54,4F,54,3A,33,31,32,2E,33,34,24} -> db sequence 80,54,4F,54,3A,
//    33,31,32,2E,33,34,24 (first rs=0, rest rs=1), 12 E pulses of 3 cycles, done at cycle 132.
//  2 row=1, dat with chars 1..4 = 7'h00 -> first write db=C0; chars 1..4 sent as 20.
//  3 start re-pulsed at cycles 5 and 60 with different dat -> ignored; output matches first dat; one done.
//  4 rst asserted mid E_HIGH of write 4 -> lcd_e=0, busy=0, db=00 same cycle (async); new start after
//    release runs full 12-write sequence from address command.
//  5 LCD_INIT_EN: after rst, busy=1, first E after 20+2 cycles, db 38,38,38,0C,01,06; E after 01 followed
//    by 9-cycle wait; busy falls, no done; subsequent start behaves as test 1.
//  6 Check RS/DB never change while lcd_e=1 and lcd_rw=0 always (assertion across all tests).

Source files
------------

// File: rtl/lcd_line_writer_pkg.sv
// Shared definitions for the HD44780 line writer: LCD command bytes,
// FSM/timer encodings, line geometry and character helpers.
package lcd_line_writer_pkg;

    localparam int unsigned CHARS_PER_LINE = 11;
    localparam int unsigned CHAR_W         = 7;
    localparam int unsigned LINE_W         = CHARS_PER_LINE * CHAR_W;
    localparam int unsigned DB_W           = 8;
    localparam int unsigned IDX_W          = 4;
    localparam int unsigned CNT_W          = 20;
    localparam int unsigned INIT_IDX_W     = 3;
    localparam int unsigned PH_W           = 3;

    localparam logic [IDX_W-1:0]      LAST_CHAR_IDX = IDX_W'(CHARS_PER_LINE - 1);
    localparam logic [INIT_IDX_W-1:0] INIT_LAST     = INIT_IDX_W'(5);

    // HD44780 command / data constants
    localparam logic [DB_W-1:0] FUNC_SET_8B2L = 8'h38;
    localparam logic [DB_W-1:0] DISP_ON       = 8'h0C;
    localparam logic [DB_W-1:0] CMD_CLR       = 8'h01;
    localparam logic [DB_W-1:0] ENTRY_INC     = 8'h06;
    localparam logic [DB_W-1:0] DDRAM_ROW0    = 8'h80;
    localparam logic [DB_W-1:0] DDRAM_ROW1    = 8'hC0;
    localparam logic [DB_W-1:0] ASCII_SPACE   = 8'h20;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_SETUP      = 4'd1,
        ST_E_HIGH     = 4'd2,
        ST_WAIT       = 4'd3,
        ST_NEXT       = 4'd4,
        ST_FIN        = 4'd5,
        ST_INIT_START = 4'd6,
        ST_INIT_PWR   = 4'd7
    } state_e;

    typedef enum logic [PH_W-1:0] {
        PH_NONE     = 3'd0,
        PH_SETUP    = 3'd1,
        PH_E_HIGH   = 3'd2,
        PH_WAIT     = 3'd3,
        PH_WAIT_CLR = 3'd4,
        PH_PWR      = 3'd5
    } phase_e;

    // Payload presented on the LCD pins for one write
    typedef struct packed {
        logic            rs;
        logic [DB_W-1:0] db;
    } lcd_bus_t;

    // Extract character idx (0 = leftmost) from a packed line
    function automatic logic [CHAR_W-1:0] get_char(input logic [LINE_W-1:0] line,
                                                   input logic [IDX_W-1:0]  idx);
        logic [CHAR_W-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < CHARS_PER_LINE; i++) begin
            if (idx == IDX_W'(i)) begin
                c = line[(CHARS_PER_LINE - 1 - i) * CHAR_W +: CHAR_W];
            end
        end
        return c;
    endfunction

    // NUL characters are shown as blanks
    function automatic logic [DB_W-1:0] char_to_db(input logic [CHAR_W-1:0] c);
        return (c == '0) ? ASCII_SPACE : {1'b0, c};
    endfunction

    // Power-on init command sequence
    function automatic logic [DB_W-1:0] init_cmd(input logic [INIT_IDX_W-1:0] idx);
        logic [DB_W-1:0] cmd;
        case (idx)
            3'd0, 3'd1, 3'd2: cmd = FUNC_SET_8B2L;
            3'd3:             cmd = DISP_ON;
            3'd4:             cmd = CMD_CLR;
            default:          cmd = ENTRY_INC;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/lcd_write_timer.sv
// Loadable down-counter that times one phase of an LCD write.
// Ports:
//   clk, rst       clock, async active-high reset
//   load           start timing a new phase this cycle
//   load_phase     phase to time (phase_e encoding)
//   setup_done_c   last cycle of the setup phase
//   e_high_done_c  last cycle of the E-high phase
//   wait_done_c    last cycle of a wait phase (normal, clear or power-on)
module lcd_write_timer
    import lcd_line_writer_pkg::*;
#(
    parameter int unsigned SETUP_CYC    = 2,
    parameter int unsigned E_HIGH_CYC   = 12,
    parameter int unsigned WAIT_CYC     = 2000,
    parameter int unsigned CLR_WAIT_CYC = 82000,
    parameter int unsigned PWR_WAIT_CYC = 750000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [PH_W-1:0] load_phase,
    output logic            setup_done_c,
    output logic            e_high_done_c,
    output logic            wait_done_c
);

    phase_e           phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expired_c;

    // Counter reload value: phase length minus one, so the phase lasts exactly N cycles
    function automatic logic [CNT_W-1:0] len_m1(input phase_e ph);
        logic [CNT_W-1:0] v;
        case (ph)
            PH_SETUP:    v = CNT_W'(SETUP_CYC - 1);
            PH_E_HIGH:   v = CNT_W'(E_HIGH_CYC - 1);
            PH_WAIT:     v = CNT_W'(WAIT_CYC - 1);
            PH_WAIT_CLR: v = CNT_W'(CLR_WAIT_CYC - 1);
            PH_PWR:      v = CNT_W'(PWR_WAIT_CYC - 1);
            default:     v = '0;
        endcase
        return v;
    endfunction

    // Next count / phase
    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        if (load) begin
            phase_d = phase_e'(load_phase);
            cnt_d   = len_m1(phase_e'(load_phase));
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= PH_NONE;
            cnt_q   <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
        end
    end

    // Phase completion flags
    always_comb begin
        expired_c     = (cnt_q == '0);
        setup_done_c  = expired_c && (phase_q == PH_SETUP);
        e_high_done_c = expired_c && (phase_q == PH_E_HIGH);
        wait_done_c   = expired_c && ((phase_q == PH_WAIT) || (phase_q == PH_WAIT_CLR) ||
                                      (phase_q == PH_PWR));
    end

endmodule

// File: rtl/lcd_line_writer.sv
// Writes one packed 11-character line to a row of an HD44780 16x2 LCD
// (8-bit mode): a DDRAM set-address command followed by 11 data writes.
// Optional power-on init sequence when the LCD_INIT_EN macro is defined.
// Ports:
//   clk, rst   clock, async active-high reset
//   start      one-cycle request, sampled only while busy=0
//   row        target row (0 -> DDRAM 0x00, 1 -> DDRAM 0x40)
//   dat        packed line, char0 in [76:70] .. char10 in [6:0]
//   busy       line (or init) in progress
//   done       one-cycle pulse when a line is fully written
//   lcd_rs/rw/e/db  LCD pins (rw tied low)
module lcd_line_writer
    import lcd_line_writer_pkg::*;
#(
    parameter int unsigned SETUP_CYC    = 2,
    parameter int unsigned E_HIGH_CYC   = 12,
    parameter int unsigned WAIT_CYC     = 2000,
    parameter int unsigned CLR_WAIT_CYC = 82000,
    parameter int unsigned PWR_WAIT_CYC = 750000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              row,
    input  logic [LINE_W-1:0] dat,
    output logic              busy,
    output logic              done,
    output logic              lcd_rs,
    output logic              lcd_rw,
    output logic              lcd_e,
    output logic [DB_W-1:0]   lcd_db
);

    state_e            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              e_q, e_d;
    lcd_bus_t          bus_q, bus_d;
    logic [LINE_W-1:0] dat_q, dat_d;
    logic [IDX_W-1:0]  char_idx_q, char_idx_d;
    logic              last_q, last_d;
`ifdef LCD_INIT_EN
    logic [INIT_IDX_W-1:0] init_idx_q, init_idx_d;
    logic                  in_init_q, in_init_d;
`endif

    logic   tmr_load_c;
    phase_e tmr_phase_c;
    logic   setup_done_c, e_high_done_c, wait_done_c;

    lcd_write_timer #(
        .SETUP_CYC   (SETUP_CYC),
        .E_HIGH_CYC  (E_HIGH_CYC),
        .WAIT_CYC    (WAIT_CYC),
        .CLR_WAIT_CYC(CLR_WAIT_CYC),
        .PWR_WAIT_CYC(PWR_WAIT_CYC)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .load         (tmr_load_c),
        .load_phase   (tmr_phase_c),
        .setup_done_c (setup_done_c),
        .e_high_done_c(e_high_done_c),
        .wait_done_c  (wait_done_c)
    );

    // Sequencer: address command, 11 characters, optional init commands
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        bus_d       = bus_q;
        dat_d       = dat_q;
        char_idx_d  = char_idx_q;
        last_d      = last_q;
        tmr_load_c  = 1'b0;
        tmr_phase_c = PH_NONE;
`ifdef LCD_INIT_EN
        init_idx_d  = init_idx_q;
        in_init_d   = in_init_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start && !busy_q) begin
                    dat_d       = dat;
                    char_idx_d  = '0;
                    last_d      = 1'b0;
                    bus_d.rs    = 1'b0;
                    bus_d.db    = row ? DDRAM_ROW1 : DDRAM_ROW0;
                    busy_d      = 1'b1;
                    state_d     = ST_SETUP;
                    tmr_load_c  = 1'b1;
                    tmr_phase_c = PH_SETUP;
                end
            end

            ST_SETUP: begin
                if (setup_done_c) begin
                    state_d     = ST_E_HIGH;
                    tmr_load_c  = 1'b1;
                    tmr_phase_c = PH_E_HIGH;
                end
            end

            ST_E_HIGH: begin
                if (e_high_done_c) begin
                    state_d     = ST_WAIT;
                    tmr_load_c  = 1'b1;
                    tmr_phase_c = PH_WAIT;
`ifdef LCD_INIT_EN
                    // Clear display needs the long execution time
                    if (in_init_q && (bus_q.db == CMD_CLR)) begin
                        tmr_phase_c = PH_WAIT_CLR;
                    end
`endif
                end
            end

            ST_WAIT: begin
                if (wait_done_c) begin
                    if (last_q) begin
                        state_d = ST_FIN;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_NEXT;
                    end
                end
            end

            ST_NEXT: begin
`ifdef LCD_INIT_EN
                if (in_init_q) begin
                    if (init_idx_q == INIT_LAST) begin
                        state_d   = ST_IDLE;
                        busy_d    = 1'b0;
                        in_init_d = 1'b0;
                    end else begin
                        init_idx_d  = init_idx_q + INIT_IDX_W'(1);
                        bus_d.rs    = 1'b0;
                        bus_d.db    = init_cmd(init_idx_q + INIT_IDX_W'(1));
                        state_d     = ST_SETUP;
                        tmr_load_c  = 1'b1;
                        tmr_phase_c = PH_SETUP;
                    end
                end else
`endif
                begin
                    bus_d.rs = 1'b1;
                    bus_d.db = char_to_db(get_char(dat_q, char_idx_q));
                    // Index saturates at the last character; last_q marks the final write
                    if (char_idx_q == LAST_CHAR_IDX) begin
                        last_d = 1'b1;
                    end else begin
                        char_idx_d = char_idx_q + IDX_W'(1);
                    end
                    state_d     = ST_SETUP;
                    tmr_load_c  = 1'b1;
                    tmr_phase_c = PH_SETUP;
                end
            end

            ST_FIN: begin
                state_d = ST_IDLE;
            end

`ifdef LCD_INIT_EN
            ST_INIT_START: begin
                state_d     = ST_INIT_PWR;
                tmr_load_c  = 1'b1;
                tmr_phase_c = PH_PWR;
            end

            ST_INIT_PWR: begin
                if (wait_done_c) begin
                    init_idx_d  = '0;
                    bus_d.rs    = 1'b0;
                    bus_d.db    = init_cmd('0);
                    state_d     = ST_SETUP;
                    tmr_load_c  = 1'b1;
                    tmr_phase_c = PH_SETUP;
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Strobe and done follow the state being entered so they stay registered
        e_d    = (state_d == ST_E_HIGH);
        done_d = (state_d == ST_FIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
`ifdef LCD_INIT_EN
            state_q    <= ST_INIT_START;
            busy_q     <= 1'b1;
            init_idx_q <= '0;
            in_init_q  <= 1'b1;
`else
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
`endif
            done_q     <= 1'b0;
            e_q        <= 1'b0;
            bus_q      <= '0;
            dat_q      <= '0;
            char_idx_q <= '0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            e_q        <= e_d;
            bus_q      <= bus_d;
            dat_q      <= dat_d;
            char_idx_q <= char_idx_d;
            last_q     <= last_d;
`ifdef LCD_INIT_EN
            init_idx_q <= init_idx_d;
            in_init_q  <= in_init_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign lcd_e  = e_q;
    assign lcd_rs = bus_q.rs;
    assign lcd_db = bus_q.db;
    assign lcd_rw = 1'b0;

endmodule

// File: tb/tb_lcd_line_writer.sv
// Self-checking bench for lcd_line_writer: directed and random lines checked
// against a pulse-level reference model of the LCD bus.
module tb_lcd_line_writer;

    localparam int SU = 2;
    localparam int EH = 3;
    localparam int WT = 5;
    localparam int CW = 9;
    localparam int PW = 20;
    localparam int T  = SU + EH + WT;
    localparam int LINE_CYC = 12 * (T + 1);
`ifdef LCD_INIT_EN
    localparam logic BUSY_AFTER_RST = 1'b1;
`else
    localparam logic BUSY_AFTER_RST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        row = 1'b0;
    logic [76:0] dat = '0;
    logic        busy, done, lcd_rs, lcd_rw, lcd_e;
    logic [7:0]  lcd_db;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] db;
        logic       rs;
        int         rise;
        int         len;
    } pulse_t;

    pulse_t pq[$];
    int     done_q[$];
    logic   done_busy_q[$];
    pulse_t cur;
    logic   e_prev = 1'b0;

    lcd_line_writer #(
        .SETUP_CYC(SU), .E_HIGH_CYC(EH), .WAIT_CYC(WT),
        .CLR_WAIT_CYC(CW), .PWR_WAIT_CYC(PW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .row(row), .dat(dat),
        .busy(busy), .done(done), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_e(lcd_e), .lcd_db(lcd_db)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus monitor: records every completed E pulse and every done pulse
    always @(negedge clk) begin
        if (!rst) begin
            if (lcd_e && !e_prev) begin
                cur.db = lcd_db; cur.rs = lcd_rs; cur.rise = cyc; cur.len = 1;
            end else if (lcd_e) begin
                cur.len++;
                checks++;
                assert ((lcd_db === cur.db) && (lcd_rs === cur.rs)) else begin
                    errors++;
                    $error("FAIL bus_stable: got rs=%0b db=%0h expected rs=%0b db=%0h",
                           lcd_rs, lcd_db, cur.rs, cur.db);
                end
            end else if (e_prev) begin
                pq.push_back(cur);
            end
            if (done) begin
                done_q.push_back(cyc);
                done_busy_q.push_back(busy);
            end
            if (lcd_e) begin
                checks++;
                assert (lcd_rw === 1'b0) else begin
                    errors++;
                    $error("FAIL rw_low: got %0b expected 0", lcd_rw);
                end
            end
        end
        e_prev = rst ? 1'b0 : lcd_e;
    end

    // Reference: byte expected on write k of a line (k=0 is the address command)
    function automatic logic [7:0] exp_db(input logic r, input logic [76:0] d, input int k);
        logic [76:0] sh;
        int c;
        if (k == 0) return r ? 8'hC0 : 8'h80;
        sh = d >> (7 * (11 - k));
        c  = int'(sh[6:0]);
        return (c == 0) ? 8'h20 : 8'(c);
    endfunction

    function automatic logic [76:0] rand_line();
        logic [76:0] d;
        d = '0;
        for (int i = 0; i < 11; i++) begin
            d = d << 7;
            if ($urandom_range(0, 3) != 0) d[6:0] = 7'($urandom_range(1, 127));
        end
        return d;
    endfunction

    task automatic start_line(input logic r, input logic [76:0] d, output int s);
        pq.delete(); done_q.delete(); done_busy_q.delete();
        @(negedge clk);
        start = 1'b1; row = r; dat = d;
        @(posedge clk);
        #1;
        s = cyc;
        chk("busy_after_start", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_line(input logic r, input logic [76:0] d, input int s, input string tag);
        chk({tag, "_npulse"}, 32'(pq.size()), 32'd12);
        for (int k = 0; k < 12 && k < pq.size(); k++) begin
            chk($sformatf("%s_db%0d", tag, k), 32'(pq[k].db), 32'(exp_db(r, d, k)));
            chk($sformatf("%s_rs%0d", tag, k), 32'(pq[k].rs), (k == 0) ? 32'd0 : 32'd1);
            chk($sformatf("%s_rise%0d", tag, k), 32'(pq[k].rise), 32'(s + (T + 1) * k + SU));
            chk($sformatf("%s_elen%0d", tag, k), 32'(pq[k].len), 32'(EH));
        end
        chk({tag, "_ndone"}, 32'(done_q.size()), 32'd1);
        if (done_q.size() > 0) begin
            chk({tag, "_done_cyc"}, 32'(done_q[0] - s + 1), 32'(LINE_CYC));
            chk({tag, "_done_busy"}, 32'(done_busy_q[0]), 32'd0);
        end
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    // Run one line; when extra is set, re-pulse start with other data while busy and in FIN
    task automatic do_line(input logic r, input logic [76:0] d, input bit extra, input string tag);
        int s;
        start_line(r, d, s);
        for (int n = 2; n <= LINE_CYC + 20; n++) begin
            @(negedge clk);
            if (extra && (n == 5 || n == 60 || n == LINE_CYC)) begin
                start = 1'b1; row = ~r; dat = ~d;
            end else begin
                start = 1'b0;
            end
        end
        check_line(r, d, s, tag);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [76:0] d1, d2;
        int s;
        d1 = {7'h54, 7'h4F, 7'h54, 7'h3A, 7'h33, 7'h31, 7'h32, 7'h2E, 7'h33, 7'h34, 7'h24};
        d2 = {7'h41, 7'h00, 7'h00, 7'h00, 7'h00, 7'h42, 7'h43, 7'h44, 7'h45, 7'h46, 7'h00};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'(BUSY_AFTER_RST));
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_e", 32'(lcd_e), 32'd0);
        chk("rst_rs", 32'(lcd_rs), 32'd0);
        chk("rst_rw", 32'(lcd_rw), 32'd0);
        chk("rst_db", 32'(lcd_db), 32'd0);
        rst = 1'b0;

`ifdef LCD_INIT_EN
        // Power-on init sequence
        @(negedge clk);
        chk("init_busy", 32'(busy), 32'd1);
        wait_idle(PW + 6 * (T + 1) + 40, "init");
        chk("init_npulse", 32'(pq.size()), 32'd6);
        for (int k = 0; k < 6 && k < pq.size(); k++) begin
            logic [7:0] want;
            case (k)
                0, 1, 2: want = 8'h38;
                3:       want = 8'h0C;
                4:       want = 8'h01;
                default: want = 8'h06;
            endcase
            chk($sformatf("init_db%0d", k), 32'(pq[k].db), 32'(want));
            chk($sformatf("init_rs%0d", k), 32'(pq[k].rs), 32'd0);
            if (k > 0)
                chk($sformatf("init_gap%0d", k), 32'(pq[k].rise - pq[k-1].rise),
                    (k == 5) ? 32'(SU + EH + CW + 1) : 32'(T + 1));
        end
        chk("init_no_done", 32'(done_q.size()), 32'd0);
`else
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
`endif

        // Directed lines
        do_line(1'b0, d1, 1'b0, "t1");
        do_line(1'b1, d2, 1'b0, "t2");
        do_line(1'b0, d1, 1'b1, "t3");

        // Async reset in the middle of E-high of write 4
        start_line(1'b1, d2, s);
        for (int n = 0; n < 200 && !(pq.size() == 4 && lcd_e === 1'b1); n++) @(negedge clk);
        chk("t4_reach_w4", 32'(pq.size() == 4 && lcd_e === 1'b1), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t4_e", 32'(lcd_e), 32'd0);
        chk("t4_busy", 32'(busy), 32'(BUSY_AFTER_RST));
        chk("t4_db", 32'(lcd_db), 32'd0);
        chk("t4_rs", 32'(lcd_rs), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_idle(PW + 6 * (T + 1) + 40, "t4_rel");
        repeat (30) @(negedge clk);
        chk("t4_no_done", 32'(done_q.size()), 32'd0);
        do_line(1'b0, d1, 1'b0, "t4_rerun");

        // Random lines
        for (int i = 0; i < 4; i++) begin
            do_line(1'($urandom_range(0, 1)), rand_line(), 1'($urandom_range(0, 1)),
                    $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
